// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU: sequencer state codes, opcode and
// instruction-field constants, and the default halt encoding.
package cpu_pkg;

   localparam int unsigned INSTR_W = 16;
   localparam int unsigned STATE_W = 2;

   localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
   localparam logic [STATE_W-1:0] ST_FETCH = 2'd1;
   localparam logic [STATE_W-1:0] ST_EXEC  = 2'd2;
   localparam logic [STATE_W-1:0] ST_HALT  = 2'd3;

   localparam logic [3:0]         OP_BEQ            = 4'b1110;
   localparam logic [INSTR_W-1:0] HALT_WORD_DEFAULT = 16'hFFFF;

   localparam int unsigned OPCODE_MSB = 15;
   localparam int unsigned OPCODE_LSB = 12;
   localparam int unsigned IMM_MSB    = 5;
   localparam int unsigned IMM_LSB    = 0;
   localparam int unsigned IMM_W      = IMM_MSB - IMM_LSB + 1;

endpackage

// File: rtl/fetch_sequencer_pc_next.sv
// Next-PC adder: pc + 1, plus the sign-extended 6-bit immediate when a branch
// is taken. Arithmetic wraps modulo 2^PC_W.
module pc_next
   import cpu_pkg::*;
#(
   parameter int unsigned PC_W = 8
) (
   input  logic [PC_W-1:0]  pc,
   input  logic [IMM_W-1:0] imm,
   input  logic             take,
   output logic [PC_W-1:0]  next_pc
);

   logic [PC_W-1:0] offset;

   always_comb begin
      offset  = take ? PC_W'($signed(imm)) : '0;
      next_pc = pc + PC_W'(1) + offset;
   end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch / PC sequencer: owns the PC, fetches over a req/ack
// handshake, presents one instruction per EXEC cycle and gates register writes.
module fetch_sequencer
   import cpu_pkg::*;
#(
   parameter int unsigned         PC_W      = 8,
   parameter logic [PC_W-1:0]     RESET_PC  = '0,
   parameter logic [INSTR_W-1:0]  HALT_WORD = HALT_WORD_DEFAULT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   output logic               imem_req,
   output logic [PC_W-1:0]    imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic [INSTR_W-1:0] instr,
   output logic               instr_valid,
   input  logic               branch,
   input  logic               alu_zero,
   input  logic               reg_write_in,
   output logic               reg_write_en,
   output logic [PC_W-1:0]    pc,
   output logic [15:0]        retired,
   output logic               busy,
   output logic               halted
);

   localparam int unsigned     RET_W   = 16;
   localparam logic [RET_W-1:0] RET_MAX = '1;

   logic [STATE_W-1:0] state_q, state_d;
   logic [PC_W-1:0]    pc_q, pc_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic [RET_W-1:0]   retired_q, retired_d;

   logic               is_halt;
   logic               take_branch;
   logic [PC_W-1:0]    pc_adv;

   assign is_halt     = (instr_q == HALT_WORD);
   assign take_branch = (state_q == ST_EXEC) && branch && alu_zero;

   pc_next #(.PC_W(PC_W)) u_pc_next (
      .pc      (pc_q),
      .imm     (instr_q[IMM_MSB:IMM_LSB]),
      .take    (take_branch),
      .next_pc (pc_adv)
   );

   // Next-state and datapath register updates
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      instr_d   = instr_q;
      retired_d = retired_q;
      case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_FETCH;
         end
         ST_FETCH: begin
            if (imem_ack) begin
               instr_d = imem_rdata;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (is_halt) begin
               state_d = ST_HALT;
            end else begin
               pc_d    = pc_adv;
               state_d = ST_FETCH;
               if (retired_q != RET_MAX) retired_d = retired_q + RET_W'(1);
            end
         end
         ST_HALT: begin
            // Resume skips past the halt word; take_branch is low here.
            if (start) begin
               pc_d    = pc_adv;
               state_d = ST_FETCH;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         pc_q      <= RESET_PC;
         instr_q   <= '0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         instr_q   <= instr_d;
         retired_q <= retired_d;
      end
   end

   // Control outputs decode directly from the state register
   always_comb begin
      imem_req     = (state_q == ST_FETCH);
      instr_valid  = (state_q == ST_EXEC);
      busy         = (state_q == ST_FETCH) || (state_q == ST_EXEC);
      halted       = (state_q == ST_HALT);
      reg_write_en = (state_q == ST_EXEC) && reg_write_in && !is_halt;
      imem_addr    = pc_q;
      pc           = pc_q;
      instr        = instr_q;
      retired      = retired_q;
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed test-plan scenarios with
// literal expectations, then randomized traffic against a behavioural model.
module tb_fetch_sequencer;

   localparam int unsigned PC_W   = 8;
   localparam int          PC_MOD = 1 << PC_W;
   localparam int          M_IDLE = 0, M_FETCH = 1, M_EXEC = 2, M_HALT = 3;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            start = 1'b0;
   logic            imem_req;
   logic [PC_W-1:0] imem_addr;
   logic            imem_ack = 1'b0;
   logic [15:0]     imem_rdata = 16'h0;
   logic [15:0]     instr;
   logic            instr_valid;
   logic            branch = 1'b0;
   logic            alu_zero = 1'b0;
   logic            reg_write_in = 1'b0;
   logic            reg_write_en;
   logic [PC_W-1:0] pc;
   logic [15:0]     retired;
   logic            busy;
   logic            halted;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en   = 1'b0;

   // Behavioural model state
   int          m_mode  = M_IDLE;
   int          m_pc    = 0;
   int          m_ret   = 0;
   logic [15:0] m_instr = 16'h0;

   fetch_sequencer #(.PC_W(PC_W), .RESET_PC(8'd0), .HALT_WORD(16'hFFFF)) dut (
      .clk(clk), .rst(rst), .start(start),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
      .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid),
      .branch(branch), .alu_zero(alu_zero), .reg_write_in(reg_write_in),
      .reg_write_en(reg_write_en), .pc(pc), .retired(retired),
      .busy(busy), .halted(halted)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Model advances on the same edge as the DUT, from the inputs held across it
   always @(posedge clk) begin
      if (rst) begin
         m_mode  <= M_IDLE;
         m_pc    <= 0;
         m_instr <= 16'h0;
         m_ret   <= 0;
      end else begin
         case (m_mode)
            M_IDLE:  if (start) m_mode <= M_FETCH;
            M_FETCH: if (imem_ack) begin
               m_instr <= imem_rdata;
               m_mode  <= M_EXEC;
            end
            M_EXEC: if (m_instr == 16'hFFFF) begin
               m_mode <= M_HALT;
            end else begin
               m_pc   <= (m_pc + 1 + ((branch && alu_zero) ? int'($signed(m_instr[5:0])) : 0)
                          + PC_MOD) % PC_MOD;
               m_ret  <= (m_ret < 65535) ? m_ret + 1 : m_ret;
               m_mode <= M_FETCH;
            end
            default: if (start) begin
               m_pc   <= (m_pc + 1) % PC_MOD;
               m_mode <= M_FETCH;
            end
         endcase
      end
   end

   // Compare every cycle on the falling edge
   always @(negedge clk) begin
      if (chk_en) begin
         chk("imem_req",     32'(imem_req),     32'(m_mode == M_FETCH));
         chk("instr_valid",  32'(instr_valid),  32'(m_mode == M_EXEC));
         chk("busy",         32'(busy),         32'(m_mode == M_FETCH || m_mode == M_EXEC));
         chk("halted",       32'(halted),       32'(m_mode == M_HALT));
         chk("reg_write_en", 32'(reg_write_en),
             32'(m_mode == M_EXEC && reg_write_in && m_instr != 16'hFFFF));
         chk("pc",           32'(pc),           32'(m_pc));
         chk("instr",        32'(instr),        32'(m_instr));
         chk("retired",      32'(retired),      32'(m_ret));
         if (imem_req) chk("imem_addr", 32'(imem_addr), 32'(m_pc));
      end
   end

   // One fetch + execute with zero-wait or delayed ack
   task automatic run_instr(input logic [15:0] w, input int waits,
                            input logic br, input logic az, input logic rw);
      for (int n = 0; n < 20 && !imem_req; n++) tick();
      chk("req_seen", 32'(imem_req), 32'd1);
      for (int i = 0; i < waits; i++) tick();
      imem_ack = 1'b1; imem_rdata = w;
      tick();
      imem_ack = 1'b0;
      branch = br; alu_zero = az; reg_write_in = rw;
      tick();
      branch = 1'b0; alu_zero = 1'b0; reg_write_in = 1'b0;
   endtask

   initial begin
      int req_cycles;
      logic [15:0] r_snap;

      // Reset and start with zero-wait memory
      tick();
      chk_en = 1'b1;
      chk("rst_pc", 32'(pc), 32'd0);
      chk("rst_instr", 32'(instr), 32'd0);
      chk("rst_retired", 32'(retired), 32'd0);
      chk("rst_ctrl", 32'({imem_req, instr_valid, reg_write_en, busy, halted}), 32'd0);
      rst = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      chk("start_req", 32'(imem_req), 32'd1);
      chk("start_addr", 32'(imem_addr), 32'd0);
      imem_ack = 1'b1; imem_rdata = 16'h0E45;
      tick();
      imem_ack = 1'b0;
      chk("first_instr", 32'(instr), 32'h0E45);
      chk("first_valid", 32'(instr_valid), 32'd1);
      reg_write_in = 1'b1;
      #1;
      chk("first_rwe", 32'(reg_write_en), 32'd1);
      tick();
      reg_write_in = 1'b0;
      chk("first_pc", 32'(pc), 32'd1);
      chk("first_retired", 32'(retired), 32'd1);

      // Three wait states: req held four cycles at a stable address
      req_cycles = 0;
      for (int i = 0; i < 3; i++) begin
         if (imem_req && imem_addr == 8'd1) req_cycles++;
         tick();
      end
      if (imem_req && imem_addr == 8'd1) req_cycles++;
      imem_ack = 1'b1; imem_rdata = 16'h1111;
      tick();
      imem_ack = 1'b0;
      chk("wait_req_cycles", 32'(req_cycles), 32'd4);
      chk("wait_valid", 32'(instr_valid), 32'd1);
      tick();
      chk("wait_valid_once", 32'(instr_valid), 32'd0);
      chk("wait_pc", 32'(pc), 32'd2);

      // BEQ taken / not taken from pc=10
      for (int i = 0; i < 8; i++) run_instr(16'h0000, 0, 1'b0, 1'b0, 1'b0);
      chk("pc_at_10", 32'(pc), 32'd10);
      run_instr(16'hE03D, 0, 1'b1, 1'b1, 1'b0);
      chk("beq_taken", 32'(pc), 32'd8);
      run_instr(16'h0000, 1, 1'b0, 1'b0, 1'b0);
      run_instr(16'h0000, 0, 1'b0, 1'b0, 1'b0);
      run_instr(16'hE03D, 0, 1'b1, 1'b0, 1'b0);
      chk("beq_not_taken", 32'(pc), 32'd11);

      // Wrap at the top of the address space, then negative branch below 0
      for (int i = 0; i < 244; i++) run_instr(16'h1234, 0, 1'b0, 1'b1, 1'b1);
      chk("pc_at_255", 32'(pc), 32'd255);
      run_instr(16'h0000, 0, 1'b0, 1'b0, 1'b0);
      chk("wrap_to_0", 32'(pc), 32'd0);
      run_instr(16'h0000, 0, 1'b0, 1'b0, 1'b0);
      run_instr(16'hE03B, 0, 1'b1, 1'b1, 1'b0);
      chk("wrap_neg_branch", 32'(pc), 32'd253);

      // Halt at pc=4, sticky until start, then resume from 5
      for (int i = 0; i < 7; i++) run_instr(16'h0000, 0, 1'b0, 1'b0, 1'b0);
      chk("pc_at_4", 32'(pc), 32'd4);
      r_snap = retired;
      run_instr(16'hFFFF, 2, 1'b1, 1'b1, 1'b1);
      chk("halt_flag", 32'(halted), 32'd1);
      chk("halt_pc", 32'(pc), 32'd4);
      chk("halt_retired", 32'(retired), 32'(r_snap));
      tick(); tick();
      chk("halt_sticky", 32'(halted), 32'd1);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("resume_req", 32'(imem_req), 32'd1);
      chk("resume_addr", 32'(imem_addr), 32'd5);

      // Reset coincident with ack discards the fetch
      imem_ack = 1'b1; imem_rdata = 16'h1234; rst = 1'b1;
      tick();
      imem_ack = 1'b0; rst = 1'b0;
      chk("rstmid_req", 32'(imem_req), 32'd0);
      chk("rstmid_instr", 32'(instr), 32'd0);
      chk("rstmid_pc", 32'(pc), 32'd0);
      chk("rstmid_idle", 32'({busy, halted}), 32'd0);

      // Randomized traffic checked by the model every cycle
      for (int cyc = 0; cyc < 4000; cyc++) begin
         int kind;
         rst          = ($urandom_range(0, 299) == 0);
         start        = ($urandom_range(0, 3) == 0);
         branch       = $urandom_range(0, 1) == 1;
         alu_zero     = $urandom_range(0, 1) == 1;
         reg_write_in = $urandom_range(0, 1) == 1;
         imem_ack     = imem_req && ($urandom_range(0, 2) != 0);
         kind         = $urandom_range(0, 9);
         if (kind == 0)      imem_rdata = 16'hFFFF;
         else if (kind < 4)  imem_rdata = {4'hE, 6'($urandom), 6'($urandom)};
         else                imem_rdata = 16'($urandom);
         tick();
      end
      rst = 1'b0; start = 1'b0; imem_ack = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
